// File: rtl/uart_file_loader_pkg.sv
// rtl/uart_file_loader_pkg.sv - UART register map, loader FSM states and byte-lane helper
package uart_file_loader_pkg;

    localparam logic [2:0] UART_WRITE_WAIT = 3'd0;
    localparam logic [2:0] UART_DIV_REG    = 3'd1;
    localparam logic [2:0] UART_DATA       = 3'd2;
    localparam logic [2:0] UART_SOFT_RESET = 3'd3;
    localparam logic [2:0] UART_READ_VALID = 3'd4;
    localparam logic [2:0] UART_RXEN       = 3'd5;

    typedef enum logic [3:0] {
        S_CFG_RST1,
        S_CFG_RST0,
        S_CFG_DIV,
        S_CFG_RXEN,
        S_IDLE,
        S_TX_POLL,
        S_TX_WR,
        S_RX_POLL,
        S_RX_READ,
        S_MEM_WR,
        S_DONE,
        S_ERR
    } state_e;

    function automatic logic [31:0] insert_lane(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [7:0] data);
        logic [31:0] res;
        res = word;
        res[8*lane +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/uart_file_loader_reg_master.sv
// rtl/uart_file_loader_reg_master.sv - single-access UART register bus handshake
module uart_reg_master (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        uart_sel_o,
    output logic [2:0]  uart_addr_o,
    output logic        uart_write_o,
    output logic        uart_read_o,
    output logic [31:0] uart_wdata_o,
    input  logic [31:0] uart_rdata_i,
    input  logic        uart_ready_i
);

    logic        sel_q;
    logic        we_q;
    logic [2:0]  addr_q;
    logic [31:0] wdata_q;

    // A new request is only latched while no access is open, so the cycle after
    // an ack always shows the strobes low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (sel_q) begin
            if (uart_ready_i) begin
                sel_q   <= 1'b0;
                we_q    <= 1'b0;
                addr_q  <= '0;
                wdata_q <= '0;
            end
        end else if (req_i) begin
            sel_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign ack_o        = sel_q & uart_ready_i;
    assign rdata_o      = uart_rdata_i;
    assign uart_sel_o   = sel_q;
    assign uart_addr_o  = addr_q;
    assign uart_write_o = sel_q & we_q;
    assign uart_read_o  = sel_q & ~we_q;
    assign uart_wdata_o = wdata_q;

endmodule

// File: rtl/uart_file_loader.sv
// rtl/uart_file_loader.sv - UART file receiver writing packed payload words to memory
module uart_file_loader
    import uart_file_loader_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] UART_DIV = 32'd868,
    parameter logic [ADDR_W-1:0] MEM_BASE = '0,
    parameter logic [31:0] MAX_SIZE = 32'd16777216,
    parameter logic [7:0]  REQ_CHAR = 8'h02
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [31:0]       file_size_o,
    output logic              uart_sel_o,
    output logic [2:0]        uart_addr_o,
    output logic              uart_write_o,
    output logic              uart_read_o,
    output logic [31:0]       uart_wdata_o,
    input  logic [31:0]       uart_rdata_i,
    input  logic              uart_ready_i,
    output logic              mem_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_ready_i
);

    state_e              state_q, state_d;
    logic                error_q, error_d;
    logic                data_phase_q, data_phase_d;
    logic [31:0]         file_size_q, file_size_d;
    logic [31:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-3:0]   word_cnt_q, word_cnt_d;
    logic [31:0]         word_q, word_d;

    logic                req, we, ack;
    logic [2:0]          addr;
    logic [31:0]         wdata, rdata;
    logic [7:0]          rx_byte;
    logic [31:0]         size_new;

    uart_reg_master u_reg_master (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .ack_o        (ack),
        .rdata_o      (rdata),
        .uart_sel_o   (uart_sel_o),
        .uart_addr_o  (uart_addr_o),
        .uart_write_o (uart_write_o),
        .uart_read_o  (uart_read_o),
        .uart_wdata_o (uart_wdata_o),
        .uart_rdata_i (uart_rdata_i),
        .uart_ready_i (uart_ready_i)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_CFG_RST1;
            error_q      <= 1'b0;
            data_phase_q <= 1'b0;
            file_size_q  <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            error_q      <= error_d;
            data_phase_q <= data_phase_d;
            file_size_q  <= file_size_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_q       <= word_d;
        end
    end

    assign rx_byte  = rdata[7:0];
    assign size_new = insert_lane(file_size_q, byte_cnt_q[1:0], rx_byte);

    always_comb begin
        state_d      = state_q;
        error_d      = error_q;
        data_phase_d = data_phase_q;
        file_size_d  = file_size_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_d       = word_q;
        req          = 1'b0;
        we           = 1'b0;
        addr         = '0;
        wdata        = '0;
        case (state_q)
            S_CFG_RST1: begin
                req = 1'b1; we = 1'b1; addr = UART_SOFT_RESET; wdata = 32'd1;
                if (ack) state_d = S_CFG_RST0;
            end
            S_CFG_RST0: begin
                req = 1'b1; we = 1'b1; addr = UART_SOFT_RESET; wdata = 32'd0;
                if (ack) state_d = S_CFG_DIV;
            end
            S_CFG_DIV: begin
                req = 1'b1; we = 1'b1; addr = UART_DIV_REG; wdata = UART_DIV;
                if (ack) state_d = S_CFG_RXEN;
            end
            S_CFG_RXEN: begin
                req = 1'b1; we = 1'b1; addr = UART_RXEN; wdata = 32'd1;
                if (ack) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (start_i) begin
                    error_d      = 1'b0;
                    data_phase_d = 1'b0;
                    file_size_d  = '0;
                    byte_cnt_d   = '0;
                    word_cnt_d   = '0;
                    word_d       = '0;
                    state_d      = S_TX_POLL;
                end
            end
            S_TX_POLL: begin
                req = 1'b1; addr = UART_WRITE_WAIT;
                if (ack && rdata == '0) state_d = S_TX_WR;
            end
            S_TX_WR: begin
                req = 1'b1; we = 1'b1; addr = UART_DATA; wdata = {24'd0, REQ_CHAR};
                if (ack) state_d = S_RX_POLL;
            end
            S_RX_POLL: begin
                req = 1'b1; addr = UART_READ_VALID;
                if (ack && rdata != '0) state_d = S_RX_READ;
            end
            S_RX_READ: begin
                req = 1'b1; addr = UART_DATA;
                if (ack) begin
                    if (!data_phase_q) begin
                        // Header bytes reuse byte_cnt as the size-lane index.
                        file_size_d = size_new;
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            byte_cnt_d = '0;
                            if (size_new == '0 || size_new > MAX_SIZE) begin
                                error_d = 1'b1;
                                state_d = S_ERR;
                            end else begin
                                data_phase_d = 1'b1;
                                state_d      = S_RX_POLL;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + 32'd1;
                            state_d    = S_RX_POLL;
                        end
                    end else begin
                        word_d     = insert_lane(word_q, byte_cnt_q[1:0], rx_byte);
                        byte_cnt_d = byte_cnt_q + 32'd1;
                        if (byte_cnt_q[1:0] == 2'd3 || byte_cnt_d == file_size_q)
                            state_d = S_MEM_WR;
                        else
                            state_d = S_RX_POLL;
                    end
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    word_cnt_d = word_cnt_q + (ADDR_W-2)'(1);
                    word_d     = '0;
                    state_d    = (byte_cnt_q == file_size_q) ? S_DONE : S_RX_POLL;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_CFG_RST1;
        endcase
    end

    assign busy_o      = (state_q == S_TX_POLL) || (state_q == S_TX_WR) || (state_q == S_RX_POLL) ||
                         (state_q == S_RX_READ) || (state_q == S_MEM_WR);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = error_q;
    assign file_size_o = file_size_q;
    assign mem_valid_o = (state_q == S_MEM_WR);
    assign mem_addr_o  = MEM_BASE + {word_cnt_q, 2'b00};
    assign mem_wdata_o = word_q;
    assign mem_wstrb_o = 4'hF;

endmodule

// File: tb/tb_uart_file_loader.sv
// tb/tb_uart_file_loader.sv - UART/memory models and directed transfers for uart_file_loader
module tb_uart_file_loader;
    import uart_file_loader_pkg::*;

    localparam logic [31:0] TB_BASE = 32'h0000_1000;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic        busy, done, error;
    logic [31:0] file_size;
    logic        uart_sel, uart_write, uart_read, uart_ready = 1'b0;
    logic [2:0]  uart_addr;
    logic [31:0] uart_wdata, uart_rdata = '0;
    logic        mem_valid, mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    uart_file_loader #(.MEM_BASE(TB_BASE)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .error_o(error),
        .file_size_o(file_size), .uart_sel_o(uart_sel), .uart_addr_o(uart_addr),
        .uart_write_o(uart_write), .uart_read_o(uart_read), .uart_wdata_o(uart_wdata),
        .uart_rdata_i(uart_rdata), .uart_ready_i(uart_ready), .mem_valid_o(mem_valid),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb), .mem_ready_i(mem_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART peripheral model
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_chars[$];
    logic [2:0]  cfg_addr[$];
    logic [31:0] cfg_data[$];
    int ww_left = 0, ww_reads = 0, data_reads = 0, sel_cycles = 0;
    bit          u_act = 0;
    int          u_lat = 0;
    logic [2:0]  u_addr;
    logic        u_we;
    logic [31:0] u_wd;

    always @(negedge clk) begin
        uart_ready = 1'b0;
        uart_rdata = '0;
        if (rst) begin
            u_act = 0;
        end else if (uart_sel) begin
            sel_cycles++;
            check("uart_one_of_rw", {63'd0, uart_read ^ uart_write}, 64'd1);
            if (!u_act) begin
                u_act = 1; u_lat = $urandom_range(0, 2);
                u_addr = uart_addr; u_we = uart_write; u_wd = uart_wdata;
            end else begin
                check("uart_stable", {uart_addr, uart_write, uart_wdata}, {u_addr, u_we, u_wd});
            end
            if (u_lat == 0) begin
                uart_ready = 1'b1;
                u_act = 0;
                if (u_we) begin
                    if (u_addr == UART_DATA) tx_chars.push_back(u_wd[7:0]);
                    else begin
                        cfg_addr.push_back(u_addr);
                        cfg_data.push_back(u_wd);
                        if (u_addr == UART_SOFT_RESET && u_wd[0]) rx_q.delete();
                    end
                end else begin
                    case (u_addr)
                        UART_WRITE_WAIT: begin
                            ww_reads++;
                            if (ww_left > 0) begin uart_rdata = 32'd1; ww_left--; end
                        end
                        UART_READ_VALID: uart_rdata = (rx_q.size() > 0) ? 32'd1 : 32'd0;
                        UART_DATA: begin
                            data_reads++;
                            if (rx_q.size() > 0) uart_rdata = {24'd0, rx_q.pop_front()};
                        end
                        default: ;
                    endcase
                end
            end else u_lat--;
        end
    end

    // Memory model with stalls and expected-write scoreboard
    logic [31:0] exp_addr[$], exp_data[$], log_addr[$], log_data[$];
    int          mem_hold = 0;
    bit          m_act = 0;
    logic [31:0] m_addr, m_data;

    always @(negedge clk) begin
        mem_ready = 1'b0;
        if (rst) begin
            m_act = 0;
        end else if (mem_valid) begin
            if (m_act) check("mem_stable", {mem_addr, mem_wdata}, {m_addr, m_data});
            else begin
                m_act = 1; m_addr = mem_addr; m_data = mem_wdata;
                check("mem_wstrb", {60'd0, mem_wstrb}, 64'hF);
            end
            if (mem_hold > 0) mem_hold--;
            else if ($urandom_range(0, 2) != 0) begin
                mem_ready = 1'b1;
                m_act = 0;
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                check("mem_expected_pending", {63'd0, exp_addr.size() > 0}, 64'd1);
                if (exp_addr.size() > 0) begin
                    check("mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr.pop_front()});
                    check("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_data.pop_front()});
                end
            end
        end
    end

    int   done_cnt = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_pulse_width", {63'd0, prev_done}, 64'd0);
            check("done_busy_bus", {61'd0, busy, uart_sel, mem_valid}, 64'd0);
        end
        if (error) check("error_busy_bus", {61'd0, busy, uart_sel, mem_valid}, 64'd0);
        prev_done = done;
    end

    logic [7:0] pay[$];

    task automatic check_cfg(input string tag);
        logic [2:0]  ea[4] = '{UART_SOFT_RESET, UART_SOFT_RESET, UART_DIV_REG, UART_RXEN};
        logic [31:0] ed[4] = '{32'd1, 32'd0, 32'd868, 32'd1};
        int t = 0;
        while (cfg_addr.size() < 4 && t < 500) begin @(posedge clk); #1; t++; end
        check({tag, "_cfg_count"}, 64'(cfg_addr.size()), 64'd4);
        for (int i = 0; i < 4 && i < cfg_addr.size(); i++) begin
            check({tag, "_cfg_addr"}, {61'd0, cfg_addr[i]}, {61'd0, ea[i]});
            check({tag, "_cfg_data"}, {32'd0, cfg_data[i]}, {32'd0, ed[i]});
        end
        cfg_addr.delete();
        cfg_data.delete();
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] size, input bit ok);
        int w0 = log_addr.size();
        int d0 = done_cnt;
        int t = 0;
        logic [31:0] w;
        exp_addr.delete(); exp_data.delete(); tx_chars.delete();
        if (ok) begin
            for (int i = 0; i < (pay.size() + 3) / 4; i++) begin
                w = '0;
                for (int j = 0; j < 4; j++)
                    if (4 * i + j < pay.size()) w[8*j +: 8] = pay[4*i+j];
                exp_addr.push_back(TB_BASE + 32'(4 * i));
                exp_data.push_back(w);
            end
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy_on_start"}, {63'd0, busy}, 64'd1);
        check({tag, "_error_cleared"}, {63'd0, error}, 64'd0);
        while (tx_chars.size() == 0 && t < 2000) begin @(posedge clk); #1; t++; end
        check({tag, "_req_char"}, (tx_chars.size() > 0) ? {56'd0, tx_chars[0]} : 64'hDEAD, 64'h02);
        for (int k = 0; k < 4; k++) rx_q.push_back(size[8*k +: 8]);
        for (int i = 0; i < pay.size(); i++) rx_q.push_back(pay[i]);
        t = 0;
        while (done_cnt == d0 && !error && t < 20000) begin @(posedge clk); #1; t++; end
        check({tag, "_finished_in_time"}, {63'd0, t < 20000}, 64'd1);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        if (ok) begin
            check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
            check({tag, "_no_error"}, {63'd0, error}, 64'd0);
            check({tag, "_file_size"}, {32'd0, file_size}, {32'd0, size});
            check({tag, "_write_count"}, 64'(log_addr.size() - w0), 64'((pay.size() + 3) / 4));
            check({tag, "_all_words_seen"}, 64'(exp_addr.size()), 64'd0);
        end else begin
            check({tag, "_error_set"}, {63'd0, error}, 64'd1);
            check({tag, "_no_done"}, 64'(done_cnt - d0), 64'd0);
            check({tag, "_no_writes"}, 64'(log_addr.size() - w0), 64'd0);
        end
        rx_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int s0, w0, t, dr0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {25'd0, file_size, busy, done, error, uart_sel, uart_read, uart_write, mem_valid}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_cfg("boot");
        s0 = sel_cycles;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_uart", 64'(sel_cycles - s0), 64'd0);
        check("start_in_cfg_dropped", {63'd0, busy}, 64'd0);
        check("no_request_sent", 64'(tx_chars.size()), 64'd0);

        w0 = log_addr.size();
        pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_xfer("size8", 32'd8, 1'b1);
        if (log_addr.size() >= w0 + 2) begin
            check("size8_word0", {log_addr[w0], log_data[w0]}, {32'h0000_1000, 32'h4433_2211});
            check("size8_word1", {log_addr[w0+1], log_data[w0+1]}, {32'h0000_1004, 32'h8877_6655});
        end

        w0 = log_addr.size();
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_xfer("size5", 32'd5, 1'b1);
        if (log_addr.size() >= w0 + 2) begin
            check("size5_word0", {log_addr[w0], log_data[w0]}, {32'h0000_1000, 32'hDDCC_BBAA});
            check("size5_word1", {log_addr[w0+1], log_data[w0+1]}, {32'h0000_1004, 32'h0000_00EE});
        end

        pay.delete();
        run_xfer("size0", 32'd0, 1'b0);
        run_xfer("size_over", 32'h0100_0001, 1'b0);
        pay = {8'h5A};
        run_xfer("size1_after_err", 32'd1, 1'b1);

        pay.delete();
        for (int i = 0; i < 12; i++) pay.push_back(8'(8'hC0 + i));
        s0 = ww_reads;
        ww_left = 50;
        mem_hold = 20;
        run_xfer("stall", 32'd12, 1'b1);
        check("stall_ww_polls", 64'(ww_reads - s0), 64'd51);

        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'(8'h30 + i));
        dr0 = data_reads;
        exp_addr.delete(); exp_data.delete();
        exp_addr.push_back(TB_BASE); exp_data.push_back(32'h3332_3130);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4; k++) rx_q.push_back(8'(k == 0 ? 16 : 0));
        for (int i = 0; i < pay.size(); i++) rx_q.push_back(pay[i]);
        t = 0;
        while (data_reads < dr0 + 10 && t < 5000) begin @(posedge clk); #1; t++; end
        check("midrst_reached_byte6", {63'd0, t < 5000}, 64'd1);
        rst = 1'b1;
        cfg_addr.delete(); cfg_data.delete();
        @(posedge clk); #1;
        check("midrst_outputs", {25'd0, file_size, busy, done, error, uart_sel, uart_read, uart_write, mem_valid}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_addr.delete(); exp_data.delete(); rx_q.delete();
        check_cfg("midrst");
        pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_xfer("after_rst", 32'd6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
